usequencer_fsm: RTL and testbench
=================================

# usequencer_fsm

Hardwired control unit for the ARC-style micro datapath. It fetches an instruction through a request/acknowledge handshake, decodes the IR fields, and sequences the datapath one microstep per cycle by driving the A/B mux selects, the C-bus write decoder, the ALU function, and the IR/PSR/shifter load strobes. It sits beside uDataPath inside the system top level and closes the loop the datapath leaves open: IR fields and PSR flags come in, control words go out.

## Interface
- DATAWIDTH_DECODER_SELECTION, 6: C-bus write-select width; value 63 means no write.
- DATAWIDTH_MUX_SELECTION, 6: A/B bus source-select width.
- DATAWIDTH_ALU_SELECTION, 4: ALU function width.
- REG_PC, 32: register index of PC. REG_IR, 37: register index of IR. REG_LINK, 15: call link register.

- usequencer_CLOCK_50  in  1  single system clock; all state updates on its rising edge.
- usequencer_Reset_InLow  in  1  asynchronous, active-low reset.
- usequencer_Run_InHigh  in  1  leave IDLE and start executing.
- usequencer_FetchAck_InHigh  in  1  instruction word valid on the IR load path this cycle.
- RegIR_OP 2, RegIR_RD 5, RegIR_OP2 3, RegIR_OP3 6, RegIR_RS1 5, RegIR_BIT13 1, RegIR_RS2 5  in  IR fields; RD[3:0] doubles as the branch condition.
- PSR_N/Z/V/C_InHigh  in  1 each  current PSR flags.
- usequencer_FetchReq_OutHigh  out  1  instruction fetch request.
- usequencer_RegIRLoad_OutHigh  out  1  load IR.
- usequencer_PSRLoad_OutHigh  out  1  latch ALU flags into PSR.
- usequencer_RegSHIFTERLoad_OutHigh  out  1  shifter load.
- usequencer_MuxA_Out / MuxB_Out  out  6  bus A/B source index.
- usequencer_Decoder_Out  out  6  C-bus destination index; 63 means none.
- usequencer_ALU_Out  out  4  ALU function.
- usequencer_Illegal_OutHigh  out  1  sticky unsupported-opcode flag.
- usequencer_State_Out  out  4  current state, for debug.

## Operation
- ALU codes: ANDCC 0, ORCC 1, ORNCC 2, ADDCC 3, SRL 4, AND 5, OR 6, ADD 8, ADD_DISP22 9 (A + sext(disp22)<<2), ADD_DISP30 10 (A + disp30<<2), INCPC 14 (A + 4).
- States: IDLE, FETCH, DECODE, EXEC_ALU, EXEC_CALL, EXEC_JMPL, BR_TEST, PC_TGT, PC_INC.
- All outputs are decoded from the state register and IR fields only (Moore-style), with two exceptions: RegIRLoad equals FetchAck while in FETCH, and PC_TGT versus PC_INC selection reads the PSR in BR_TEST.
- Defaults in every state: Decoder=63, all strobes 0, MuxA/MuxB/ALU=0.
- IDLE: no outputs asserted. Go to FETCH when Run=1.
- FETCH: FetchReq=1 held until FetchAck=1. On the ack cycle RegIRLoad=1, then go to DECODE.
- DECODE: one cycle with no outputs. Next state by opcode:
  - OP=2 with OP3 in {010000, 010001, 010010, 010110, 100110}: EXEC_ALU.
  - OP=2 with OP3=111000: EXEC_JMPL.
  - OP=1: EXEC_CALL.
  - OP=0 with OP2=010: BR_TEST.
  - Anything else: set Illegal, go to PC_INC.
- EXEC_ALU: MuxA=RS1; MuxB=RS2 when BIT13=0, else REG_IR (ALU sign-extends simm13); Decoder=RD; ALU from OP3 (ADDCC/ANDCC/ORCC/ORNCC/SRL); PSRLoad=1 except for SRL. If RD=0, Decoder=63 (r0 is never written). Then PC_INC.
- EXEC_CALL: MuxA=REG_PC, ALU=ADD(B=0), Decoder=REG_LINK, then PC_TGT.
- EXEC_JMPL: MuxA=RS1, MuxB per BIT13 as in EXEC_ALU, ALU=ADD, Decoder=REG_PC. Then FETCH; RD link write is not supported.
- BR_TEST: evaluate cond = RD[3:0]:
  - 0001 taken if Z; 0101 if C; 0110 if N; 0111 if V; 1000 always.
  - Any other code is never taken and does not set Illegal.
  - Taken goes to PC_TGT, otherwise PC_INC.
- PC_TGT: MuxA=REG_PC, MuxB=REG_IR, Decoder=REG_PC. ALU=ADD_DISP30 if OP=1, else ADD_DISP22. Then FETCH.
- PC_INC: MuxA=REG_PC, ALU=INCPC, Decoder=REG_PC, then FETCH.
- Run=0 is sampled only in PC_INC, PC_TGT and EXEC_JMPL. When low, the next state is IDLE instead of FETCH, so the current instruction always completes.
- Illegal clears only on reset.
- RegSHIFTERLoad=1 only in EXEC_ALU when OP3=SRL.

## Timing
- Reset (asynchronous on the Reset_InLow falling edge, held while low): state=IDLE, Decoder=63, all other outputs 0, Illegal=0.
- Leaving reset: the first FETCH is the cycle after the first clock edge that samples Run=1.
- Minimum cycles per instruction with FetchAck on the first FETCH cycle:
  - ALU op: 4 (FETCH, DECODE, EXEC_ALU, PC_INC).
  - Branch: 4 (FETCH, DECODE, BR_TEST, PC_TGT or PC_INC).
  - CALL: 4 (FETCH, DECODE, EXEC_CALL, PC_TGT).
  - JMPL: 3.
- Each FETCH wait cycle adds 1. FetchReq stays high continuously, with no gap, until the ack.
- FetchAck outside FETCH is ignored.
- Reset asserted in any state aborts the instruction immediately. No partial write strobe survives, because Decoder goes to 63 asynchronously.

## Test plan
- Reset low, then release with Run=1 and Ack held high: state IDLE→FETCH→DECODE; FetchReq=1 for exactly 1 cycle; RegIRLoad pulses once.
- ADDCC r3,r1,r2 (OP=2, OP3=010000, RD=3, RS1=1, RS2=2, BIT13=0): EXEC_ALU drives MuxA=1, MuxB=2, Decoder=3, ALU=3, PSRLoad=1; next cycle PC_INC drives Decoder=32, ALU=14.
- BE with Z=1 reaches PC_TGT with ALU=9, Decoder=32; BE with Z=0 reaches PC_INC instead; BA is taken regardless of flags.
- CALL (OP=1): EXEC_CALL drives Decoder=15; PC_TGT drives ALU=10; then FETCH.
- Hold Ack low for 5 cycles in FETCH: FetchReq stays 1 for 6 cycles and the state does not advance. Ack during DECODE is ignored.
- OP=3 (load): Illegal=1, then PC_INC, and Illegal stays 1 through the next instructions. Assert reset mid-EXEC_ALU: Decoder=63 immediately, Illegal=0.

Source files
------------

// File: rtl/usequencer_fsm_if.sv
// usequencer_fsm_if: IR fields, PSR flags, fetch handshake and control word between sequencer and datapath.
interface usequencer_fsm_if #(
    parameter int DATAWIDTH_DECODER_SELECTION = 6,
    parameter int DATAWIDTH_MUX_SELECTION = 6,
    parameter int DATAWIDTH_ALU_SELECTION = 4
);
    logic usequencer_Run_InHigh;
    logic usequencer_FetchAck_InHigh;
    logic [1:0] RegIR_OP;
    logic [4:0] RegIR_RD;
    logic [2:0] RegIR_OP2;
    logic [5:0] RegIR_OP3;
    logic [4:0] RegIR_RS1;
    logic RegIR_BIT13;
    logic [4:0] RegIR_RS2;
    logic PSR_N_InHigh;
    logic PSR_Z_InHigh;
    logic PSR_V_InHigh;
    logic PSR_C_InHigh;
    logic usequencer_FetchReq_OutHigh;
    logic usequencer_RegIRLoad_OutHigh;
    logic usequencer_PSRLoad_OutHigh;
    logic usequencer_RegSHIFTERLoad_OutHigh;
    logic [DATAWIDTH_MUX_SELECTION-1:0] usequencer_MuxA_Out;
    logic [DATAWIDTH_MUX_SELECTION-1:0] usequencer_MuxB_Out;
    logic [DATAWIDTH_DECODER_SELECTION-1:0] usequencer_Decoder_Out;
    logic [DATAWIDTH_ALU_SELECTION-1:0] usequencer_ALU_Out;
    logic usequencer_Illegal_OutHigh;
    logic [3:0] usequencer_State_Out;

    modport master (
        input usequencer_Run_InHigh, usequencer_FetchAck_InHigh,
        input RegIR_OP, RegIR_RD, RegIR_OP2, RegIR_OP3, RegIR_RS1, RegIR_BIT13, RegIR_RS2,
        input PSR_N_InHigh, PSR_Z_InHigh, PSR_V_InHigh, PSR_C_InHigh,
        output usequencer_FetchReq_OutHigh, usequencer_RegIRLoad_OutHigh, usequencer_PSRLoad_OutHigh,
        output usequencer_RegSHIFTERLoad_OutHigh, usequencer_MuxA_Out, usequencer_MuxB_Out,
        output usequencer_Decoder_Out, usequencer_ALU_Out, usequencer_Illegal_OutHigh, usequencer_State_Out
    );

    modport slave (
        output usequencer_Run_InHigh, usequencer_FetchAck_InHigh,
        output RegIR_OP, RegIR_RD, RegIR_OP2, RegIR_OP3, RegIR_RS1, RegIR_BIT13, RegIR_RS2,
        output PSR_N_InHigh, PSR_Z_InHigh, PSR_V_InHigh, PSR_C_InHigh,
        input usequencer_FetchReq_OutHigh, usequencer_RegIRLoad_OutHigh, usequencer_PSRLoad_OutHigh,
        input usequencer_RegSHIFTERLoad_OutHigh, usequencer_MuxA_Out, usequencer_MuxB_Out,
        input usequencer_Decoder_Out, usequencer_ALU_Out, usequencer_Illegal_OutHigh, usequencer_State_Out
    );
endinterface

// File: rtl/usequencer_fsm.sv
// usequencer_fsm: hardwired fetch/decode/execute sequencer producing one registered control word per cycle.
module usequencer_fsm #(
    parameter int DATAWIDTH_DECODER_SELECTION = 6,
    parameter int DATAWIDTH_MUX_SELECTION = 6,
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int REG_PC = 32,
    parameter int REG_IR = 37,
    parameter int REG_LINK = 15
) (
    input logic usequencer_CLOCK_50,
    input logic usequencer_Reset_InLow,
    usequencer_fsm_if.master bus
);
    localparam int DW_D = DATAWIDTH_DECODER_SELECTION;
    localparam int DW_M = DATAWIDTH_MUX_SELECTION;
    localparam int DW_A = DATAWIDTH_ALU_SELECTION;
    localparam logic [DW_M-1:0] M_NONE = '0;
    localparam logic [DW_M-1:0] M_PC = DW_M'(REG_PC);
    localparam logic [DW_M-1:0] M_IR = DW_M'(REG_IR);
    localparam logic [DW_D-1:0] D_NONE = '1;
    localparam logic [DW_D-1:0] D_PC = DW_D'(REG_PC);
    localparam logic [DW_D-1:0] D_LINK = DW_D'(REG_LINK);
    localparam logic [DW_A-1:0] A_ANDCC = DW_A'(0);
    localparam logic [DW_A-1:0] A_ORCC = DW_A'(1);
    localparam logic [DW_A-1:0] A_ORNCC = DW_A'(2);
    localparam logic [DW_A-1:0] A_ADDCC = DW_A'(3);
    localparam logic [DW_A-1:0] A_SRL = DW_A'(4);
    localparam logic [DW_A-1:0] A_ADD = DW_A'(8);
    localparam logic [DW_A-1:0] A_DISP22 = DW_A'(9);
    localparam logic [DW_A-1:0] A_DISP30 = DW_A'(10);
    localparam logic [DW_A-1:0] A_INCPC = DW_A'(14);
    localparam logic [5:0] OP3_ADDCC = 6'b010000;
    localparam logic [5:0] OP3_ANDCC = 6'b010001;
    localparam logic [5:0] OP3_ORCC = 6'b010010;
    localparam logic [5:0] OP3_ORNCC = 6'b010110;
    localparam logic [5:0] OP3_SRL = 6'b100110;
    localparam logic [5:0] OP3_JMPL = 6'b111000;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_ALU, S_EXEC_CALL, S_EXEC_JMPL, S_BR_TEST, S_PC_TGT, S_PC_INC
    } state_t;

    state_t r_state, w_next, w_resume;
    logic r_req, r_psr, r_shf, r_ill;
    logic [DW_M-1:0] r_muxa, r_muxb;
    logic [DW_D-1:0] r_dec;
    logic [DW_A-1:0] r_alu;
    logic w_req, w_psr, w_shf, w_ill_set;
    logic [DW_M-1:0] w_muxa, w_muxb, w_srcb;
    logic [DW_D-1:0] w_dec, w_rd_dst;
    logic [DW_A-1:0] w_alu, w_alu_fn;
    logic w_is_alu, w_is_jmpl, w_is_call, w_is_br, w_taken;
    logic [3:0] w_cond;

    assign w_is_alu = bus.RegIR_OP == 2'd2 &&
        (bus.RegIR_OP3 inside {OP3_ADDCC, OP3_ANDCC, OP3_ORCC, OP3_ORNCC, OP3_SRL});
    assign w_is_jmpl = bus.RegIR_OP == 2'd2 && bus.RegIR_OP3 == OP3_JMPL;
    assign w_is_call = bus.RegIR_OP == 2'd1;
    assign w_is_br = bus.RegIR_OP == 2'd0 && bus.RegIR_OP2 == 3'b010;
    assign w_ill_set = r_state == S_DECODE && !(w_is_alu || w_is_jmpl || w_is_call || w_is_br);
    assign w_alu_fn = bus.RegIR_OP3 == OP3_ADDCC ? A_ADDCC :
                      bus.RegIR_OP3 == OP3_ANDCC ? A_ANDCC :
                      bus.RegIR_OP3 == OP3_ORCC  ? A_ORCC  :
                      bus.RegIR_OP3 == OP3_ORNCC ? A_ORNCC : A_SRL;
    assign w_srcb = bus.RegIR_BIT13 ? M_IR : DW_M'(bus.RegIR_RS2);
    assign w_rd_dst = bus.RegIR_RD == 5'd0 ? D_NONE : DW_D'(bus.RegIR_RD);
    assign w_cond = bus.RegIR_RD[3:0];
    assign w_taken = w_cond == 4'b0001 ? bus.PSR_Z_InHigh :
                     w_cond == 4'b0101 ? bus.PSR_C_InHigh :
                     w_cond == 4'b0110 ? bus.PSR_N_InHigh :
                     w_cond == 4'b0111 ? bus.PSR_V_InHigh : w_cond == 4'b1000;
    // Run is only consulted where an instruction finishes, so stopping never truncates one
    assign w_resume = bus.usequencer_Run_InHigh ? S_FETCH : S_IDLE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = bus.usequencer_Run_InHigh ? S_FETCH : S_IDLE;
            S_FETCH:     w_next = bus.usequencer_FetchAck_InHigh ? S_DECODE : S_FETCH;
            S_DECODE:    w_next = w_is_alu ? S_EXEC_ALU : w_is_jmpl ? S_EXEC_JMPL :
                                  w_is_call ? S_EXEC_CALL : w_is_br ? S_BR_TEST : S_PC_INC;
            S_EXEC_ALU:  w_next = S_PC_INC;
            S_EXEC_CALL: w_next = S_PC_TGT;
            S_BR_TEST:   w_next = w_taken ? S_PC_TGT : S_PC_INC;
            default:     w_next = w_resume;
        endcase
    end

    // Control word for the state being entered, so outputs leave the flops glitch-free
    always_comb begin
        w_req = 1'b0;
        w_psr = 1'b0;
        w_shf = 1'b0;
        w_muxa = M_NONE;
        w_muxb = M_NONE;
        w_dec = D_NONE;
        w_alu = '0;
        case (w_next)
            S_FETCH: w_req = 1'b1;
            S_EXEC_ALU: begin
                w_muxa = DW_M'(bus.RegIR_RS1);
                w_muxb = w_srcb;
                w_dec = w_rd_dst;
                w_alu = w_alu_fn;
                w_psr = bus.RegIR_OP3 != OP3_SRL;
                w_shf = bus.RegIR_OP3 == OP3_SRL;
            end
            S_EXEC_CALL: begin
                w_muxa = M_PC;
                w_dec = D_LINK;
                w_alu = A_ADD;
            end
            S_EXEC_JMPL: begin
                w_muxa = DW_M'(bus.RegIR_RS1);
                w_muxb = w_srcb;
                w_dec = D_PC;
                w_alu = A_ADD;
            end
            S_PC_TGT: begin
                w_muxa = M_PC;
                w_muxb = M_IR;
                w_dec = D_PC;
                w_alu = w_is_call ? A_DISP30 : A_DISP22;
            end
            S_PC_INC: begin
                w_muxa = M_PC;
                w_dec = D_PC;
                w_alu = A_INCPC;
            end
            default: w_req = 1'b0;
        endcase
    end

    always_ff @(posedge usequencer_CLOCK_50 or negedge usequencer_Reset_InLow) begin
        if (!usequencer_Reset_InLow) begin
            r_state <= S_IDLE;
            r_req <= 1'b0;
            r_psr <= 1'b0;
            r_shf <= 1'b0;
            r_ill <= 1'b0;
            r_muxa <= M_NONE;
            r_muxb <= M_NONE;
            r_dec <= D_NONE;
            r_alu <= '0;
        end else begin
            r_state <= w_next;
            r_req <= w_req;
            r_psr <= w_psr;
            r_shf <= w_shf;
            r_ill <= r_ill | w_ill_set;
            r_muxa <= w_muxa;
            r_muxb <= w_muxb;
            r_dec <= w_dec;
            r_alu <= w_alu;
        end
    end

    assign bus.usequencer_FetchReq_OutHigh = r_req;
    assign bus.usequencer_RegIRLoad_OutHigh = r_state == S_FETCH && bus.usequencer_FetchAck_InHigh;
    assign bus.usequencer_PSRLoad_OutHigh = r_psr;
    assign bus.usequencer_RegSHIFTERLoad_OutHigh = r_shf;
    assign bus.usequencer_MuxA_Out = r_muxa;
    assign bus.usequencer_MuxB_Out = r_muxb;
    assign bus.usequencer_Decoder_Out = r_dec;
    assign bus.usequencer_ALU_Out = r_alu;
    assign bus.usequencer_Illegal_OutHigh = r_ill;
    assign bus.usequencer_State_Out = r_state;
endmodule

// File: tb/tb_usequencer_fsm.sv
// tb_usequencer_fsm: random instruction stream against a per-instruction cycle model, scoreboard-checked every cycle.
module tb_usequencer_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    usequencer_fsm_if bus();
    usequencer_fsm dut (.usequencer_CLOCK_50(clk), .usequencer_Reset_InLow(rst_n), .bus(bus));

    typedef struct packed {
        logic [3:0] st;
        logic req, irl, psr, shf, ill;
        logic [5:0] ma, mb, dc;
        logic [3:0] alu;
    } ctrl_t;

    localparam int IDLE = 0, FETCH = 1, DECODE = 2, EALU = 3, ECALL = 4, EJMPL = 5, BRT = 6, PCT = 7, PCI = 8;

    ctrl_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic m_ill = 1'b0;
    logic m_idle = 1'b0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic ctrl_t mk(input int st, input int ma = 0, input int mb = 0, input int dc = 63, input int alu = 0);
        ctrl_t e;
        e = '0;
        e.st = 4'(st);
        e.req = st == FETCH;
        e.ill = m_ill;
        e.ma = 6'(ma);
        e.mb = 6'(mb);
        e.dc = 6'(dc);
        e.alu = 4'(alu);
        return e;
    endfunction

    function automatic ctrl_t dut_ctrl();
        ctrl_t g;
        g.st = bus.usequencer_State_Out;
        g.req = bus.usequencer_FetchReq_OutHigh;
        g.irl = bus.usequencer_RegIRLoad_OutHigh;
        g.psr = bus.usequencer_PSRLoad_OutHigh;
        g.shf = bus.usequencer_RegSHIFTERLoad_OutHigh;
        g.ill = bus.usequencer_Illegal_OutHigh;
        g.ma = bus.usequencer_MuxA_Out;
        g.mb = bus.usequencer_MuxB_Out;
        g.dc = bus.usequencer_Decoder_Out;
        g.alu = bus.usequencer_ALU_Out;
        return g;
    endfunction

    task automatic check(input string nm, input ctrl_t got, input ctrl_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got st=%0d req=%b irl=%b psr=%b shf=%b ill=%b ma=%0d mb=%0d dc=%0d alu=%0d | need st=%0d req=%b irl=%b psr=%b shf=%b ill=%b ma=%0d mb=%0d dc=%0d alu=%0d",
                nm, $time, got.st, got.req, got.irl, got.psr, got.shf, got.ill, got.ma, got.mb, got.dc, got.alu,
                exp.st, exp.req, exp.irl, exp.psr, exp.shf, exp.ill, exp.ma, exp.mb, exp.dc, exp.alu);
        end
    endtask

    always @(negedge clk) if (q.size() != 0) check("cycle", dut_ctrl(), q.pop_front());

    task automatic cyc(input ctrl_t e, input logic r, input logic a);
        @(posedge clk);
        #1;
        bus.usequencer_Run_InHigh = r;
        bus.usequencer_FetchAck_InHigh = a;
        q.push_back(e);
    endtask

    task automatic set_ir(input logic [1:0] op, input logic [2:0] op2, input logic [5:0] op3, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic b13, input logic [3:0] nzvc);
        bus.RegIR_OP = op;
        bus.RegIR_OP2 = op2;
        bus.RegIR_OP3 = op3;
        bus.RegIR_RD = rd;
        bus.RegIR_RS1 = rs1;
        bus.RegIR_RS2 = rs2;
        bus.RegIR_BIT13 = b13;
        {bus.PSR_N_InHigh, bus.PSR_Z_InHigh, bus.PSR_V_InHigh, bus.PSR_C_InHigh} = nzvc;
    endtask

    function automatic int alu_of(input logic [5:0] o3);
        case (o3)
            6'b010000: return 3;
            6'b010001: return 0;
            6'b010010: return 1;
            6'b010110: return 2;
            default:   return 4;
        endcase
    endfunction

    task automatic leave_idle();
        if (m_idle) begin
            cyc(mk(IDLE), 1'b0, rb());
            cyc(mk(IDLE), 1'b1, rb());
            m_idle = 1'b0;
        end
    endtask

    task automatic do_instr(input int waits, input logic run_end);
        ctrl_t e;
        int mb, dst;
        logic [3:0] cd;
        logic tk;
        logic [1:0] op;
        logic [5:0] op3;
        op = bus.RegIR_OP;
        op3 = bus.RegIR_OP3;
        cd = bus.RegIR_RD[3:0];
        mb = bus.RegIR_BIT13 ? 37 : int'(bus.RegIR_RS2);
        dst = bus.RegIR_RD == 0 ? 63 : int'(bus.RegIR_RD);
        leave_idle();
        repeat (waits) cyc(mk(FETCH), rb(), 1'b0);
        e = mk(FETCH);
        e.irl = 1'b1;
        cyc(e, rb(), 1'b1);
        cyc(mk(DECODE), rb(), rb());
        if (op == 2 && (op3 inside {6'b010000, 6'b010001, 6'b010010, 6'b010110, 6'b100110})) begin
            e = mk(EALU, int'(bus.RegIR_RS1), mb, dst, alu_of(op3));
            e.psr = op3 != 6'b100110;
            e.shf = op3 == 6'b100110;
            cyc(e, rb(), rb());
            cyc(mk(PCI, 32, 0, 32, 14), run_end, rb());
        end else if (op == 2 && op3 == 6'b111000) begin
            cyc(mk(EJMPL, int'(bus.RegIR_RS1), mb, 32, 8), run_end, rb());
        end else if (op == 1) begin
            cyc(mk(ECALL, 32, 0, 15, 8), rb(), rb());
            cyc(mk(PCT, 32, 37, 32, 10), run_end, rb());
        end else if (op == 0 && bus.RegIR_OP2 == 3'b010) begin
            tk = cd == 1 ? bus.PSR_Z_InHigh : cd == 5 ? bus.PSR_C_InHigh : cd == 6 ? bus.PSR_N_InHigh :
                 cd == 7 ? bus.PSR_V_InHigh : cd == 8;
            cyc(mk(BRT), rb(), rb());
            if (tk) cyc(mk(PCT, 32, 37, 32, 9), run_end, rb());
            else cyc(mk(PCI, 32, 0, 32, 14), run_end, rb());
        end else begin
            m_ill = 1'b1;
            cyc(mk(PCI, 32, 0, 32, 14), run_end, rb());
        end
        m_idle = !run_end;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.usequencer_Run_InHigh = 1'b1;
        bus.usequencer_FetchAck_InHigh = 1'b1;
        q.push_back(mk(IDLE));
        m_idle = 1'b0;
    endtask

    logic [5:0] alu_ops[5] = '{6'b010000, 6'b010001, 6'b010010, 6'b010110, 6'b100110};
    logic [3:0] conds[6] = '{4'd1, 4'd5, 4'd6, 4'd7, 4'd8, 4'd3};

    initial begin
        ctrl_t e;
        int k;
        bus.usequencer_Run_InHigh = 1'b0;
        bus.usequencer_FetchAck_InHigh = 1'b0;
        set_ir(2'd0, 3'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 4'd0);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", dut_ctrl(), mk(IDLE));
        set_ir(2'd2, 3'd0, 6'b010000, 5'd3, 5'd1, 5'd2, 1'b0, 4'd0);
        release_reset();
        do_instr(0, 1'b1);
        set_ir(2'd0, 3'b010, 6'd0, 5'd1, 5'd0, 5'd0, 1'b0, 4'b0100);
        do_instr(0, 1'b1);
        set_ir(2'd0, 3'b010, 6'd0, 5'd1, 5'd0, 5'd0, 1'b0, 4'b1011);
        do_instr(1, 1'b1);
        set_ir(2'd0, 3'b010, 6'd0, 5'd8, 5'd0, 5'd0, 1'b0, 4'b0000);
        do_instr(0, 1'b1);
        set_ir(2'd1, 3'd5, 6'd7, 5'd9, 5'd4, 5'd6, 1'b1, 4'd0);
        do_instr(0, 1'b1);
        set_ir(2'd2, 3'd0, 6'b100110, 5'd0, 5'd7, 5'd9, 1'b1, 4'd0);
        do_instr(5, 1'b1);
        set_ir(2'd2, 3'd0, 6'b111000, 5'd4, 5'd17, 5'd0, 1'b1, 4'd0);
        do_instr(0, 1'b0);
        set_ir(2'd3, 3'd0, 6'd0, 5'd2, 5'd0, 5'd0, 1'b0, 4'd0);
        do_instr(0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 4);
            set_ir(2'($urandom), 3'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 4'($urandom));
            if (k == 0) begin
                bus.RegIR_OP = 2'd2;
                bus.RegIR_OP3 = alu_ops[$urandom_range(0, 4)];
            end else if (k == 1) begin
                bus.RegIR_OP = 2'd2;
                bus.RegIR_OP3 = 6'b111000;
            end else if (k == 2) begin
                bus.RegIR_OP = 2'd0;
                bus.RegIR_OP2 = 3'b010;
                bus.RegIR_RD[3:0] = conds[$urandom_range(0, 5)];
            end
            do_instr($urandom_range(0, 3), $urandom_range(0, 3) != 0);
        end
        set_ir(2'd2, 3'd0, 6'b010000, 5'd5, 5'd1, 5'd2, 1'b0, 4'd0);
        leave_idle();
        e = mk(FETCH);
        e.irl = 1'b1;
        cyc(e, 1'b1, 1'b1);
        cyc(mk(DECODE), 1'b1, 1'b0);
        @(posedge clk);
        #1;
        e = mk(EALU, 1, 2, 5, 3);
        e.psr = 1'b1;
        check("exec_before_reset", dut_ctrl(), e);
        rst_n = 1'b0;
        #1;
        m_ill = 1'b0;
        check("reset_mid_exec", dut_ctrl(), mk(IDLE));
        repeat (2) @(posedge clk);
        release_reset();
        for (int i = 0; i < 20; i++) begin
            set_ir(2'($urandom), 3'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 4'($urandom));
            do_instr($urandom_range(0, 2), 1'b1);
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
